seq_multiplier: RTL and testbench
=================================

# seq_multiplier

Parametrised multi-cycle shift-add multiplier implementing the four RV32M multiply operations (MUL, MULH, MULHSU, MULHU). It is the arithmetic successor to the single-bit full adder: the full-adder cell is generalised to an N-bit ripple adder and iterated over N cycles under a small FSM. It sits beside the ALU in the execute stage and stalls the core through a start/busy/done handshake.

## Interface
- WIDTH, 32, operand and result width in bits (≥ 4)
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock domain, synchronous, active-high
- start  in  1  request; sampled only when busy = 0
- mode  in  2  00 MUL (low half), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high)
- a  in  WIDTH  multiplicand (rs1)
- b  in  WIDTH  multiplier (rs2)
- busy  out  1  operation in progress; start ignored
- done  out  1  one-cycle pulse; result valid from this cycle
- result  out  WIDTH  selected product half; held until the next accepted start

## Operation
- Reset values: busy = 0, done = 0, result = 0, FSM = IDLE, all internal registers 0.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE: on start = 1, latch mode. a_sgn = a[MSB] if mode ∈ {01, 10}, else 0. b_sgn = b[MSB] if mode = 01, else 0. Latch |a| and |b| as WIDTH-bit unsigned magnitudes (0x8000_0000 maps to 0x8000_0000). neg = a_sgn XOR b_sgn. Clear the 2·WIDTH accumulator and the counter. Go to RUN.
- RUN: each cycle, if multiplier LSB = 1, add the multiplicand into the upper accumulator half using a (WIDTH+1)-bit add. Shift the accumulator right by 1 with the carry-in at the MSB. Shift the multiplier right. Counter increments. After WIDTH iterations, go to FIX.
- FIX: if neg = 1, the product becomes the two's complement over 2·WIDTH bits. A zero product stays zero. Register result: the low half for mode 00, otherwise the high half. Go to DONE.
- DONE: done = 1 for this cycle only, busy = 0. A start in this cycle is accepted exactly as in IDLE. Otherwise go to IDLE.
- start while busy = 1: ignored. No queuing, and latched operands and mode are unchanged.
- a, b and mode are sampled only in the accepting cycle. They may change afterwards.
- rst mid-operation: on the next edge the block returns to reset values. No done pulse is issued and the partial result is discarded.

## Timing
- Start accepted at edge E0 → busy = 1 from E0 through E0+WIDTH+1.
- done = 1 and result valid after edge E0+WIDTH+2. Total latency is WIDTH+2 cycles (34 for WIDTH = 32).
- Back-to-back: a start in the done cycle gives the next done WIDTH+2 cycles later. The throughput is one result per WIDTH+2 cycles.
- busy is a registered output with no combinational path from start.
- result is a registered output. It changes only on the FIX→DONE edge or on reset.

## Structure
- Package mul_pkg holds:
  - mode encodings MUL_LO = 2'b00, MULH = 2'b01, MULHSU = 2'b10, MULHU = 2'b11
  - FSM state encoding (IDLE, RUN, FIX, DONE)
- One sub-module, rca_n: a parametrised ripple-carry adder of width N built from full-adder cells, with ports a, b, cin, sum, cout. It is instantiated with N = WIDTH for the iteration add.
- The two's-complement step in FIX uses the RTL + operator on 2·WIDTH bits, not rca_n.

## Test plan (WIDTH = 32)
- MUL, a = 7, b = 6 → result 0x0000_002A. done rises exactly 34 cycles after start and busy is high for the intervening cycles.
- a = b = 0xFFFF_FFFF:
  - MULHU → 0xFFFF_FFFE
  - MUL → 0x0000_0001
  - MULHSU → 0xFFFF_FFFF
  - MULH → 0x0000_0000
- MULH and MUL, a = 0x8000_0000, b = 0xFFFF_FFFF → MULH 0x0000_0000, MUL 0x8000_0000 (most-negative × −1).
- MULH, a = 0xFFFF_FFFB (−5), b = 0 → 0x0000_0000 (no spurious sign). MULH, a = −3, b = 5 → 0xFFFF_FFFF and MUL → 0xFFFF_FFF1.
- start re-asserted with new operands at cycle 5 of an operation → ignored, and the original result is returned. A start in the done cycle is accepted, and the second done comes 34 cycles later.
- rst asserted at iteration 10 → next cycle busy = 0, done = 0, result = 0. No done pulse follows. A fresh MUL 3×4 then returns 0x0000_000C.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential RV32M-style multiplier:
// operation encodings and the controller state type.
package mul_pkg;

  localparam logic [1:0] MUL_LO = 2'b00;
  localparam logic [1:0] MULH   = 2'b01;
  localparam logic [1:0] MULHSU = 2'b10;
  localparam logic [1:0] MULHU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/rca_n.sv
// N-bit ripple-carry adder. A chain of full-adder cells, with the carry
// rippling from bit 0 up to cout.
module rca_n #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = cin;

  // One full-adder cell per bit: sum is the parity of the three inputs and
  // carry is the majority.
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[N];

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// It multiplies the operand magnitudes unsigned over WIDTH iterations.
// The sign is then restored in a single fix-up cycle.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH;

  state_t state, state_nxt;
  logic   accept;

  logic [1:0]       mode_q;
  logic             neg;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic             last_iter;

  logic             a_sgn, b_sgn;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] addend, sum;
  logic             cout;
  logic [PW-1:0]    prod;

  assign last_iter = (cnt == CW'(WIDTH));

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. A start is accepted in IDLE and in the done cycle.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end
      end
      RUN:  if (last_iter) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: begin
        if (start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // busy and done are registered from the next state, so neither has a
  // combinational path from start.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == RUN) || (state_nxt == FIX);
      done <= (state_nxt == DONE);
    end
  end

  // Operand signs and magnitudes for the requested mode. The most-negative
  // value negates to itself, which is still the correct unsigned magnitude.
  always_comb begin
    a_sgn = ((mode == MULH) || (mode == MULHSU)) && a[WIDTH-1];
    b_sgn = (mode == MULH) && b[WIDTH-1];
    a_mag = a_sgn ? (~a + WIDTH'(1)) : a;
    b_mag = b_sgn ? (~b + WIDTH'(1)) : b;
  end

  // The multiplicand is gated by the multiplier LSB and added into the
  // upper half of the accumulator.
  assign addend = mplier[0] ? mcand : '0;

  rca_n #(.N(WIDTH)) u_rca (
    .a    (acc[PW-1:WIDTH]),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // Restore the sign over the full double-width product. A zero product
  // negates to zero.
  assign prod = neg ? (~acc + PW'(1)) : acc;

  // Datapath: latch operands on accept, iterate in RUN, register the
  // selected product half in FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= '0;
      neg    <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (accept) begin
      mode_q <= mode;
      neg    <= a_sgn ^ b_sgn;
      mcand  <= a_mag;
      mplier <= b_mag;
      acc    <= '0;
      cnt    <= '0;
    end else if ((state == RUN) && !last_iter) begin
      acc    <= {cout, sum, acc[WIDTH-1:1]};
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end else if (state == FIX) begin
      result <= (mode_q == MUL_LO) ? prod[WIDTH-1:0] : prod[PW-1:WIDTH];
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH = 32). Directed corner cases,
// then randomized operations checked against a plain-arithmetic model.
module tb_seq_multiplier;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   mode;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] result;

  int nchecks = 0;
  int nfail   = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Reference: the 64-bit product of sign- or zero-extended operands.
  function automatic logic [31:0] ref_mul(input logic [1:0] m, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] sx, ux, sy, uy, p;
    sx = {{32{x[31]}}, x};
    ux = {32'h0, x};
    sy = {{32{y[31]}}, y};
    uy = {32'h0, y};
    case (m)
      2'b00:   begin p = ux * uy; return p[31:0];  end
      2'b01:   begin p = sx * sy; return p[63:32]; end
      2'b10:   begin p = sx * uy; return p[63:32]; end
      default: begin p = ux * uy; return p[63:32]; end
    endcase
  endfunction

  // Issue one operation from the current negedge and wait, with a bound,
  // for done. lat counts edges after the accepting edge. The inputs are
  // scrambled once the start is taken. A second start can be injected at
  // offset inj_at.
  task automatic do_op(input logic [1:0] m, input logic [31:0] x, input logic [31:0] y,
                       input int inj_at, output logic [31:0] res, output int lat,
                       output int busy_bad);
    mode  = m;
    a     = x;
    b     = y;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    lat      = 0;
    busy_bad = 0;
    a        = $urandom;
    b        = $urandom;
    mode     = 2'($urandom);
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_bad++;
      if (lat == inj_at) begin
        start = 1'b1;
        a     = $urandom;
        b     = $urandom;
        mode  = 2'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (busy !== 1'b0) busy_bad++;
    res = result;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    mode  = 2'b00;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    nchecks++;
    if (busy !== 1'b0) begin nfail++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    nchecks++;
    if (done !== 1'b0) begin nfail++; $display("[TB] FAIL reset_done: got %b, expected 0", done); end
    nchecks++;
    if (result !== '0) begin nfail++; $display("[TB] FAIL reset_result: got %h, expected 0", result); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]  m;
    logic [31:0] x, y, exp;
  } vec_t;

  task automatic test_directed();
    vec_t        v[11];
    logic [31:0] res;
    int          lat, bb;
    v[0]  = '{2'b00, 32'd7,         32'd6,         32'h0000_002A};
    v[1]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    v[2]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    v[3]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    v[4]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    v[5]  = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    v[6]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    v[7]  = '{2'b01, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0000};
    v[8]  = '{2'b01, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF};
    v[9]  = '{2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1};
    v[10] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    foreach (v[i]) begin
      do_op(v[i].m, v[i].x, v[i].y, -1, res, lat, bb);
      nchecks++;
      if (res !== v[i].exp) begin
        nfail++;
        $display("[TB] FAIL directed_%0d: mode %b a %h b %h got %h, expected %h",
                 i, v[i].m, v[i].x, v[i].y, res, v[i].exp);
      end
      if (i == 0) begin
        nchecks++;
        if (lat !== LAT) begin nfail++; $display("[TB] FAIL latency: got %0d, expected %0d", lat, LAT); end
        nchecks++;
        if (bb !== 0) begin nfail++; $display("[TB] FAIL busy_window: %0d bad samples, expected 0", bb); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] res;
    int          lat, bb;
    do_op(2'b00, 32'd1234, 32'd5678, 5, res, lat, bb);
    nchecks++;
    if (res !== 32'd7006652) begin nfail++; $display("[TB] FAIL ignore_start_result: got %h, expected %h", res, 32'd7006652); end
    nchecks++;
    if (lat !== LAT) begin nfail++; $display("[TB] FAIL ignore_start_latency: got %0d, expected %0d", lat, LAT); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2;
    int          l1, l2, bb1, bb2;
    do_op(2'b11, 32'hDEAD_BEEF, 32'h1234_5678, -1, r1, l1, bb1);
    do_op(2'b01, 32'hDEAD_BEEF, 32'h1234_5678, -1, r2, l2, bb2);
    nchecks++;
    if (r1 !== ref_mul(2'b11, 32'hDEAD_BEEF, 32'h1234_5678)) begin
      nfail++; $display("[TB] FAIL b2b_first: got %h, expected %h", r1, ref_mul(2'b11, 32'hDEAD_BEEF, 32'h1234_5678));
    end
    nchecks++;
    if (r2 !== ref_mul(2'b01, 32'hDEAD_BEEF, 32'h1234_5678)) begin
      nfail++; $display("[TB] FAIL b2b_second: got %h, expected %h", r2, ref_mul(2'b01, 32'hDEAD_BEEF, 32'h1234_5678));
    end
    nchecks++;
    if (l2 !== LAT) begin nfail++; $display("[TB] FAIL b2b_latency: got %0d, expected %0d", l2, LAT); end
    nchecks++;
    if (bb2 !== 0) begin nfail++; $display("[TB] FAIL b2b_busy: %0d bad samples, expected 0", bb2); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int          lat, bb, pulses;
    mode  = 2'b00;
    a     = 32'hFFFF_0001;
    b     = 32'h0000_FFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nchecks++;
    if (busy !== 1'b0) begin nfail++; $display("[TB] FAIL midreset_busy: got %b, expected 0", busy); end
    nchecks++;
    if (done !== 1'b0) begin nfail++; $display("[TB] FAIL midreset_done: got %b, expected 0", done); end
    nchecks++;
    if (result !== '0) begin nfail++; $display("[TB] FAIL midreset_result: got %h, expected 0", result); end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    nchecks++;
    if (pulses !== 0) begin nfail++; $display("[TB] FAIL midreset_no_done: got %0d pulses, expected 0", pulses); end
    do_op(2'b00, 32'd3, 32'd4, -1, res, lat, bb);
    nchecks++;
    if (res !== 32'h0000_000C) begin nfail++; $display("[TB] FAIL midreset_fresh: got %h, expected 0000000c", res); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] x, y, res, exp;
    logic [1:0]  m;
    int          lat, bb;
    for (int i = 0; i < 40; i++) begin
      m = 2'($urandom);
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: x = 32'h8000_0000;
        1: y = 32'hFFFF_FFFF;
        2: y = 32'h0;
        default: ;
      endcase
      exp = ref_mul(m, x, y);
      do_op(m, x, y, -1, res, lat, bb);
      nchecks++;
      if (res !== exp || lat !== LAT) begin
        nfail++;
        $display("[TB] FAIL random_%0d: mode %b a %h b %h got %h lat %0d, expected %h lat %0d",
                 i, m, x, y, res, lat, exp, LAT);
      end
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end

endmodule
